// File: rtl/mb_buf.sv
// mb_buf: MBOX memory-buffer slice. It holds a block of word registers with
// per-word valid bits and a registered word select. A drain sequencer streams
// the block out in wrap-around order, and a channel FIFO can optionally swap
// halfwords as data is pushed.
module mb_buf #(
  parameter int WIDTH   = 36,
  parameter int NWORDS  = 4,
  parameter int CHDEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mbLoad,
  input  logic [$clog2(NWORDS)-1:0]  mbLoadIdx,
  input  logic [WIDTH-1:0]           mbIn,
  input  logic [$clog2(NWORDS)-1:0]  mbSel,
  input  logic                       mbSelHold,
  output logic [WIDTH-1:0]           mb,
  output logic                       mbParOdd,
  output logic [NWORDS-1:0]          mbValid,
  input  logic                       mbClear,
  input  logic                       drainStart,
  input  logic [$clog2(NWORDS)-1:0]  drainFirst,
  output logic [WIDTH-1:0]           drainData,
  output logic [$clog2(NWORDS)-1:0]  drainIdx,
  output logic                       drainValid,
  input  logic                       drainReady,
  output logic                       drainBusy,
  input  logic                       chWr,
  input  logic [WIDTH-1:0]           chIn,
  input  logic                       chReverse,
  input  logic                       chRd,
  output logic [WIDTH-1:0]           chOut,
  output logic [$clog2(CHDEPTH):0]   chCount,
  output logic                       chFull,
  output logic                       chEmpty
);

  localparam int IW   = $clog2(NWORDS);
  localparam int CW   = $clog2(CHDEPTH);
  localparam int HALF = WIDTH / 2;
  localparam logic [IW-1:0] LAST_CNT   = IW'(NWORDS - 1);
  localparam logic [CW:0]   FULL_COUNT = (CW + 1)'(CHDEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } drain_state_t;

  // ---------------------------------------------------------------------
  // Word store
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  words [NWORDS];
  logic [NWORDS-1:0] load_mask;
  logic [IW-1:0]     sel_reg;

  // Word data is not reset; only the valid bits say whether it is meaningful.
  always_ff @(posedge clk) begin
    if (mbLoad) words[mbLoadIdx] <= mbIn;
  end

  // One-hot of the word being loaded this cycle, so a clear and a load together
  // leave just the loaded word marked valid.
  always_comb begin
    load_mask = '0;
    if (mbLoad) load_mask[mbLoadIdx] = 1'b1;
  end

  // Valid bits: clear first, then OR in the load.
  always_ff @(posedge clk) begin
    if (reset) mbValid <= '0;
    else       mbValid <= (mbClear ? '0 : mbValid) | load_mask;
  end

  // Registered select, frozen while mbSelHold is high.
  always_ff @(posedge clk) begin
    if (reset)           sel_reg <= '0;
    else if (!mbSelHold) sel_reg <= mbSel;
  end

  assign mb       = words[sel_reg];
  assign mbParOdd = ^mb;

  // ---------------------------------------------------------------------
  // Drain sequencer
  // ---------------------------------------------------------------------
  drain_state_t state, state_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [IW-1:0] cnt, cnt_next;

  // State, word pointer and accepted-word count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and drain handshake outputs; the pointer wraps naturally
  // because NWORDS is a power of two.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    drainValid = 1'b0;
    drainBusy  = 1'b0;
    case (state)
      IDLE: begin
        if (drainStart) begin
          state_next = RUN;
          ptr_next   = drainFirst;
          cnt_next   = '0;
        end
      end
      RUN: begin
        drainValid = 1'b1;
        drainBusy  = 1'b1;
        if (drainReady) begin
          ptr_next = ptr + 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_CNT) state_next = DONE;
        end
      end
      DONE: begin
        drainBusy  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign drainData = words[ptr];
  assign drainIdx  = ptr;

  // ---------------------------------------------------------------------
  // Channel FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] fifo_mem [CHDEPTH];
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    wr_ptr;
  logic [CW:0]      count;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] push_word;

  // A pop needs data; a push needs room, or a pop freeing a slot in the
  // same cycle (which is what lets push+pop proceed while full).
  assign do_pop    = chRd && !chEmpty;
  assign do_push   = chWr && (!chFull || do_pop);
  assign push_word = chReverse ? {chIn[HALF-1:0], chIn[WIDTH-1:HALF]} : chIn;

  // FIFO storage is not reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_word;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{CW{1'b0}}, do_push} - {{CW{1'b0}}, do_pop};
    end
  end

  assign chOut   = fifo_mem[rd_ptr];
  assign chCount = count;
  assign chFull  = (count == FULL_COUNT);
  assign chEmpty = (count == '0);

endmodule
